pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage of the RISC-V pipeline. It owns the program counter, issues instruction-memory requests, and fills the IF/ID pipeline register. It is the direct consumer of the branch unit's `PC_sel` and `branch_PC`: a taken branch or jump redirects the PC, squashes the wrong-path fetch and pulses a flush to the ID/EX register. A small FSM absorbs multi-cycle instruction-memory latency and redirects that arrive while a fetch is still outstanding.

## Interface
- `PC_W`, 9: PC width in bits. Byte address; bits [1:0] always 0.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard-unit load-use stall; hold PC and IF/ID.
- `pc_sel` in 1: branch unit; 1 = redirect to `branch_pc` this cycle.
- `branch_pc` in 32: redirect target; only bits [PC_W-1:0] are used, and bits [1:0] are forced to 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_W: fetch address (equals the current PC).
- `imem_ready` in 1: `imem_rdata` is valid for `imem_addr` this cycle.
- `imem_rdata` in 32: instruction word.
- `ifid_pc` out PC_W: PC of the instruction held in IF/ID.
- `ifid_instr` out 32: instruction held in IF/ID.
- `ifid_valid` out 1: IF/ID holds a real instruction (0 = bubble).
- `flush_idex` out 1: one-cycle pulse telling the ID/EX register to squash its contents.

## Operation
- FSM states:
  - FETCH: normal issue.
  - WAIT: memory busy.
  - DISCARD: memory busy and a redirect is pending.
- `imem_req` is 1 in every state while `reset` is low.
- `imem_addr` = `pc` and must remain stable while `imem_ready` is 0.
- Priority, highest first: `reset` > `pc_sel` > `imem_ready`/WAIT handling > `stall`.
- FETCH, `pc_sel`=1, `imem_ready`=1:
  - `pc` <= target.
  - IF/ID <= bubble (`ifid_valid`=0, `ifid_instr`=32'h00000013).
  - `flush_idex` pulses.
  - Stay in FETCH.
- FETCH or WAIT, `pc_sel`=1, `imem_ready`=0:
  - `redir_pc` <= target.
  - IF/ID <= bubble.
  - `flush_idex` pulses.
  - Go to DISCARD.
- DISCARD:
  - A new `pc_sel` overwrites `redir_pc` (newest wins) and pulses `flush_idex` again.
  - On `imem_ready`=1: the response is dropped, `pc` <= `redir_pc`, go to FETCH. IF/ID stays a bubble.
- FETCH, `imem_ready`=1, no redirect:
  - `stall`=0: IF/ID <= {`pc`, `imem_rdata`, 1}; `pc` <= `pc`+4.
  - `stall`=1: PC and IF/ID hold; the fetched word is re-fetched next cycle (no capture buffer).
- FETCH/WAIT, `imem_ready`=0, no redirect:
  - Go to (or stay in) WAIT; `pc` holds.
  - `stall`=0: IF/ID <= bubble.
  - `stall`=1: IF/ID holds.
- WAIT, `imem_ready`=1: behaves as FETCH with ready, and returns to FETCH.
- Arithmetic: `pc`+4 is modulo 2^PC_W; the wrap from max to 0 is silent.
- Reset values:
  - `pc`=`RESET_PC`; state=FETCH.
  - `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=32'h00000013.
  - `flush_idex`=0; `redir_pc`=0.
  - `imem_req`=0 while `reset` is asserted.
- Reset mid-operation (in WAIT or DISCARD) abandons the outstanding request; the next fetch after reset is at `RESET_PC`.

## Timing
- Zero-wait memory: one instruction per cycle. `ifid_*` are registered and valid the cycle after `imem_ready`.
- Redirect:
  - `pc_sel` in cycle N: `imem_addr`=target in N+1 (FETCH case).
  - `flush_idex`=1 in N+1 only (registered).
  - IF/ID is a bubble in N+1.
- DISCARD adds latency equal to the remaining memory wait plus 1 cycle before the target is issued.
- No combinational path from `pc_sel` or `branch_pc` to `imem_addr`; all outputs except `imem_req`/`imem_addr` are registered. `imem_addr` is driven from registered `pc`.

## Structure
- A shared pipeline package holds:
  - `fetch_state_t` (FETCH, WAIT, DISCARD).
  - `NOP_INSTR` = 32'h00000013.
  - the `ctrl_transfer` encoding constants shared with the branch unit.
- One natural sub-module: `ifid_reg`, the IF/ID pipeline register with hold (stall) and bubble (flush) controls; everything else lives in `pc_fetch_unit`.

## Test plan
- Reset, zero-wait memory, no stall:
  - `imem_addr` sequence 0,4,8,12.
  - `ifid_pc` lags `imem_addr` by one cycle.
  - `ifid_valid`=1 from the second cycle after `reset` falls.
- `pc_sel`=1, `branch_pc`=0x40 while fetching 0x10:
  - next `imem_addr`=0x40.
  - `flush_idex`=1 for exactly 1 cycle.
  - `ifid_valid`=0 for that cycle.
  - next valid `ifid_pc`=0x40.
- `imem_ready` low 3 cycles at 0x08, with `pc_sel`=1 to 0x80 in the 2nd of them, then `pc_sel`=1 to 0xC0 in the 3rd:
  - the word for 0x08 is never captured.
  - the next issued address is 0xC0.
  - `flush_idex` pulses twice.
- `stall`=1 for 2 cycles at PC 0x0C:
  - `imem_addr` and IF/ID hold for 2 cycles.
  - the fetch then resumes at 0x10 with no lost or duplicated instruction.
- PC_W=9, PC=0x1FC, no redirect: next `imem_addr`=0x000.
- `reset` asserted during DISCARD:
  - next cycle `pc`=`RESET_PC`, `ifid_valid`=0, `flush_idex`=0.
  - no stale `redir_pc` is used afterward.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and the branch unit.
package pc_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Control-transfer kind reported by the branch unit alongside pc_sel.
  typedef enum logic [1:0] {
    CT_NONE   = 2'd0,
    CT_BRANCH = 2'd1,
    CT_JAL    = 2'd2,
    CT_JALR   = 2'd3
  } ctrl_transfer_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface pc_fetch_unit_if #(
  parameter int unsigned PC_W = 9
);
  import pc_fetch_unit_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise it holds.
module pc_fetch_unit_ifid_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [PC_W-1:0]    fetch_pc,
  input  logic [INSTR_W-1:0] fetch_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (bubble) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (load) begin
      ifid_pc    <= fetch_pc;
      ifid_instr <= fetch_instr;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests, absorbs memory latency and redirects.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               pc_sel,
  input  logic [31:0]        branch_pc,
  pc_fetch_unit_if.master    imem,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic               flush_idex
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] redir_pc, redir_pc_n;
  logic [PC_W-1:0] target_pc;
  logic            flush_n;
  logic            ifid_load;
  logic            ifid_bubble;
  logic            unused_branch_bits;

  assign target_pc          = {branch_pc[PC_W-1:2], 2'b00};
  assign unused_branch_bits = ^{branch_pc[31:PC_W], branch_pc[1:0]};

  assign imem.imem_req  = ~reset;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      redir_pc   <= '0;
      flush_idex <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      redir_pc   <= redir_pc_n;
      flush_idex <= flush_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    redir_pc_n  = redir_pc;
    flush_n     = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (state)
      FETCH, WAIT: begin
        if (pc_sel) begin
          flush_n     = 1'b1;
          ifid_bubble = 1'b1;
          if (imem.imem_ready) begin
            pc_n    = target_pc;
            state_n = FETCH;
          end else begin
            redir_pc_n = target_pc;
            state_n    = DISCARD;
          end
        end else if (imem.imem_ready) begin
          state_n = FETCH;
          if (!stall) begin
            ifid_load = 1'b1;
            pc_n      = pc + PC_W'(4);
          end
        end else begin
          state_n     = WAIT;
          ifid_bubble = ~stall;
        end
      end
      DISCARD: begin
        // The newest redirect wins, even if it lands on the cycle the stale word returns.
        ifid_bubble = 1'b1;
        if (pc_sel) begin
          redir_pc_n = target_pc;
          flush_n    = 1'b1;
        end
        if (imem.imem_ready) begin
          pc_n    = pc_sel ? target_pc : redir_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  pc_fetch_unit_ifid_reg #(.PC_W(PC_W)) u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .fetch_pc   (pc),
    .fetch_instr(imem.imem_rdata),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .ifid_valid (ifid_valid)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with a zero-latency imem model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam int unsigned PC_W = 9;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_sel;
  logic [31:0] branch_pc;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        flush_idex;

  int checks;
  int failures;

  pc_fetch_unit_if #(.PC_W(PC_W)) imem ();

  // Memory returns a word tagged with its own address.
  assign imem.imem_rdata = 32'hABC0_0000 | 32'(imem.imem_addr);

  pc_fetch_unit #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
    .clk       (clk),
    .reset     (rst),
    .stall     (stall),
    .pc_sel    (pc_sel),
    .branch_pc (branch_pc),
    .imem      (imem),
    .ifid_pc   (ifid_pc),
    .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid),
    .flush_idex(flush_idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem.imem_req); end
    checks++; if (imem.imem_addr !== 9'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", imem.imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ifid_valid); end
    checks++; if (ifid_pc !== 9'h000) begin failures++; $display("FAIL reset_ifid_pc got=%h exp=000", ifid_pc); end
    checks++; if (ifid_instr !== 32'h0000_0013) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", ifid_instr); end
    checks++; if (flush_idex !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", flush_idex); end
    rst = 1'b0;
    #1;
    checks++; if (imem.imem_req !== 1'b1) begin failures++; $display("FAIL req_after_reset got=%0b exp=1", imem.imem_req); end
  endtask

  task automatic test_sequential();
    logic [PC_W-1:0] exp_addr [3];
    logic [PC_W-1:0] exp_pc [3];
    exp_addr[0] = 9'h004; exp_addr[1] = 9'h008; exp_addr[2] = 9'h00C;
    exp_pc[0]   = 9'h000; exp_pc[1]   = 9'h004; exp_pc[2]   = 9'h008;
    checks++; if (imem.imem_addr !== 9'h000) begin failures++; $display("FAIL seq_addr0 got=%h exp=000", imem.imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL seq_valid0 got=%0b exp=0", ifid_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem.imem_addr !== exp_addr[i]) begin failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem.imem_addr, exp_addr[i]); end
      checks++; if (ifid_pc !== exp_pc[i] || ifid_valid !== 1'b1) begin failures++; $display("FAIL seq_ifid[%0d] got=%h/%0b exp=%h/1", i, ifid_pc, ifid_valid, exp_pc[i]); end
    end
    checks++; if (ifid_instr !== 32'hABC0_0008) begin failures++; $display("FAIL seq_instr got=%h exp=abc00008", ifid_instr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (imem.imem_addr !== 9'h00C) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=00c", i, imem.imem_addr); end
      checks++; if (ifid_pc !== 9'h008 || ifid_instr !== 32'hABC0_0008 || ifid_valid !== 1'b1) begin
        failures++; $display("FAIL stall_ifid[%0d] got=%h/%h/%0b exp=008/abc00008/1", i, ifid_pc, ifid_instr, ifid_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (ifid_pc !== 9'h00C || ifid_instr !== 32'hABC0_000C || ifid_valid !== 1'b1) begin
      failures++; $display("FAIL stall_resume got=%h/%h/%0b exp=00c/abc0000c/1", ifid_pc, ifid_instr, ifid_valid);
    end
    checks++; if (imem.imem_addr !== 9'h010) begin failures++; $display("FAIL stall_resume_addr got=%h exp=010", imem.imem_addr); end
  endtask

  task automatic test_redirect();
    pc_sel    = 1'b1;
    branch_pc = 32'hFFFF_FE43;
    tick();
    pc_sel = 1'b0;
    checks++; if (imem.imem_addr !== 9'h040) begin failures++; $display("FAIL redir_addr got=%h exp=040", imem.imem_addr); end
    checks++; if (flush_idex !== 1'b1) begin failures++; $display("FAIL redir_flush got=%0b exp=1", flush_idex); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0000_0013) begin failures++; $display("FAIL redir_bubble got=%0b/%h exp=0/00000013", ifid_valid, ifid_instr); end
    tick();
    checks++; if (flush_idex !== 1'b0) begin failures++; $display("FAIL redir_flush_end got=%0b exp=0", flush_idex); end
    checks++; if (ifid_pc !== 9'h040 || ifid_valid !== 1'b1) begin failures++; $display("FAIL redir_target got=%h/%0b exp=040/1", ifid_pc, ifid_valid); end
    checks++; if (imem.imem_addr !== 9'h044) begin failures++; $display("FAIL redir_next got=%h exp=044", imem.imem_addr); end
  endtask

  task automatic test_discard();
    int flushes;
    flushes   = 0;
    pc_sel    = 1'b1;
    branch_pc = 32'h0000_0008;
    tick();
    if (flush_idex === 1'b1) flushes++;
    pc_sel = 1'b0;
    imem.imem_ready = 1'b0;
    flushes = 0;
    tick();
    if (flush_idex === 1'b1) flushes++;
    checks++; if (imem.imem_addr !== 9'h008 || ifid_valid !== 1'b0) begin failures++; $display("FAIL wait_hold got=%h/%0b exp=008/0", imem.imem_addr, ifid_valid); end
    pc_sel = 1'b1; branch_pc = 32'h0000_0080;
    tick();
    if (flush_idex === 1'b1) flushes++;
    checks++; if (imem.imem_addr !== 9'h008) begin failures++; $display("FAIL disc_addr1 got=%h exp=008", imem.imem_addr); end
    branch_pc = 32'h0000_00C0;
    tick();
    if (flush_idex === 1'b1) flushes++;
    checks++; if (imem.imem_addr !== 9'h008 || ifid_valid !== 1'b0) begin failures++; $display("FAIL disc_addr2 got=%h/%0b exp=008/0", imem.imem_addr, ifid_valid); end
    pc_sel = 1'b0;
    imem.imem_ready = 1'b1;
    tick();
    if (flush_idex === 1'b1) flushes++;
    checks++; if (imem.imem_addr !== 9'h0C0) begin failures++; $display("FAIL disc_target got=%h exp=0c0", imem.imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin failures++; $display("FAIL disc_drop got=%0b exp=0", ifid_valid); end
    checks++; if (flushes != 2) begin failures++; $display("FAIL disc_flush_count got=%0d exp=2", flushes); end
    tick();
    checks++; if (ifid_pc !== 9'h0C0 || ifid_instr !== 32'hABC0_00C0 || ifid_valid !== 1'b1) begin
      failures++; $display("FAIL disc_first got=%h/%h/%0b exp=0c0/abc000c0/1", ifid_pc, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_wrap();
    pc_sel    = 1'b1;
    branch_pc = 32'h0000_01FC;
    tick();
    pc_sel = 1'b0;
    checks++; if (imem.imem_addr !== 9'h1FC) begin failures++; $display("FAIL wrap_pre got=%h exp=1fc", imem.imem_addr); end
    tick();
    checks++; if (imem.imem_addr !== 9'h000) begin failures++; $display("FAIL wrap_addr got=%h exp=000", imem.imem_addr); end
    checks++; if (ifid_pc !== 9'h1FC || ifid_valid !== 1'b1) begin failures++; $display("FAIL wrap_ifid got=%h/%0b exp=1fc/1", ifid_pc, ifid_valid); end
  endtask

  task automatic test_reset_in_discard();
    imem.imem_ready = 1'b0;
    pc_sel    = 1'b1;
    branch_pc = 32'h0000_0100;
    tick();
    pc_sel = 1'b0;
    checks++; if (flush_idex !== 1'b1) begin failures++; $display("FAIL rd_enter_flush got=%0b exp=1", flush_idex); end
    rst = 1'b1;
    tick();
    checks++; if (imem.imem_addr !== 9'h000 || imem.imem_req !== 1'b0) begin failures++; $display("FAIL rd_reset got=%h/%0b exp=000/0", imem.imem_addr, imem.imem_req); end
    checks++; if (ifid_valid !== 1'b0 || flush_idex !== 1'b0) begin failures++; $display("FAIL rd_outputs got=%0b/%0b exp=0/0", ifid_valid, flush_idex); end
    rst = 1'b0;
    imem.imem_ready = 1'b1;
    tick();
    checks++; if (imem.imem_addr !== 9'h004) begin failures++; $display("FAIL rd_next_addr got=%h exp=004", imem.imem_addr); end
    checks++; if (ifid_pc !== 9'h000 || ifid_valid !== 1'b1) begin failures++; $display("FAIL rd_first got=%h/%0b exp=000/1", ifid_pc, ifid_valid); end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    stall           = 1'b0;
    pc_sel          = 1'b0;
    branch_pc       = '0;
    imem.imem_ready = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_discard();
    test_wrap();
    test_reset_in_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
